// File: rtl/seq_chunk_adder.sv
// rtl/seq_chunk_adder.sv - multi-cycle chunked adder/subtractor with valid/ready handshakes (optional macro: SEQ_ADDER_OVERFLOW_EN adds the ovf port)
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef SEQ_ADDER_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic             cout
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int KW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NCHUNK - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [KW-1:0]    r_k;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_bx;
  logic             r_c;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
`ifdef SEQ_ADDER_OVERFLOW_EN
  logic             r_ovf;
  logic             w_c_msb;
`endif

  logic [CHUNK-1:0] w_a_k;
  logic [CHUNK-1:0] w_b_k;
  logic [CHUNK-1:0] w_chunk_sum;
  logic             w_carry;
  logic [WIDTH-1:0] w_acc_next;

  assign w_a_k = r_a[r_k*CHUNK +: CHUNK];
  assign w_b_k = r_bx[r_k*CHUNK +: CHUNK];

  // Ripple of full-adder cells across the current chunk, seeded by the carry register
  always_comb begin
    logic v_c;
    v_c         = r_c;
    w_chunk_sum = '0;
`ifdef SEQ_ADDER_OVERFLOW_EN
    w_c_msb     = 1'b0;
`endif
    for (int i = 0; i < CHUNK; i++) begin
`ifdef SEQ_ADDER_OVERFLOW_EN
      // After the loop this holds the carry into the chunk's top bit
      w_c_msb = v_c;
`endif
      w_chunk_sum[i] = w_a_k[i] ^ w_b_k[i] ^ v_c;
      v_c            = (w_a_k[i] & w_b_k[i]) | (v_c & (w_a_k[i] ^ w_b_k[i]));
    end
    w_carry = v_c;
  end

  // Working accumulator with the current chunk merged in
  always_comb begin
    w_acc_next                      = r_acc;
    w_acc_next[r_k*CHUNK +: CHUNK]  = w_chunk_sum;
  end

  // Control FSM, operand capture and per-chunk accumulation
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_a     <= '0;
      r_bx    <= '0;
      r_c     <= 1'b0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
`ifdef SEQ_ADDER_OVERFLOW_EN
      r_ovf   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_bx    <= b ^ {WIDTH{sub}};
            r_c     <= sub | cin;
            r_acc   <= '0;
            r_k     <= '0;
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          r_acc <= w_acc_next;
          r_c   <= w_carry;
          if (r_k == K_LAST) begin
            // Result registers only change here so they stay stable between operations
            r_sum   <= w_acc_next;
            r_cout  <= w_carry;
`ifdef SEQ_ADDER_OVERFLOW_EN
            r_ovf   <= w_carry ^ w_c_msb;
`endif
            r_state <= S_DONE;
          end else begin
            r_k <= r_k + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign out_valid = (r_state == S_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
`ifdef SEQ_ADDER_OVERFLOW_EN
  assign ovf       = r_ovf;
`endif

endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb/tb_seq_chunk_adder.sv - directed and randomised checks of seq_chunk_adder for CHUNK 1, 4 and 16
module tb_seq_chunk_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_ready;
  int          cur;
  int          total = 0;
  int          bad   = 0;

  logic        ir0, ir1, ir2;
  logic        ov0, ov1, ov2;
  logic        co0, co1, co2;
  logic [15:0] s0, s1, s2;
  logic        m_in_ready, m_out_valid, m_cout;
  logic [15:0] m_sum;
`ifdef SEQ_ADDER_OVERFLOW_EN
  logic        of0, of1, of2;
  logic        m_ovf;
`endif

  always #5 clk = ~clk;

  seq_chunk_adder #(.WIDTH(16), .CHUNK(1)) u_c1 (
    .clk(clk), .rst(rst), .in_valid(in_valid && cur == 0), .in_ready(ir0),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ov0), .out_ready(out_ready),
`ifdef SEQ_ADDER_OVERFLOW_EN
    .ovf(of0),
`endif
    .sum(s0), .cout(co0)
  );

  seq_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_c4 (
    .clk(clk), .rst(rst), .in_valid(in_valid && cur == 1), .in_ready(ir1),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ov1), .out_ready(out_ready),
`ifdef SEQ_ADDER_OVERFLOW_EN
    .ovf(of1),
`endif
    .sum(s1), .cout(co1)
  );

  seq_chunk_adder #(.WIDTH(16), .CHUNK(16)) u_c16 (
    .clk(clk), .rst(rst), .in_valid(in_valid && cur == 2), .in_ready(ir2),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(ov2), .out_ready(out_ready),
`ifdef SEQ_ADDER_OVERFLOW_EN
    .ovf(of2),
`endif
    .sum(s2), .cout(co2)
  );

  // Select the instance under test
  always_comb begin
    m_in_ready  = ir1;
    m_out_valid = ov1;
    m_sum       = s1;
    m_cout      = co1;
`ifdef SEQ_ADDER_OVERFLOW_EN
    m_ovf       = of1;
`endif
    case (cur)
      0: begin
        m_in_ready = ir0; m_out_valid = ov0; m_sum = s0; m_cout = co0;
`ifdef SEQ_ADDER_OVERFLOW_EN
        m_ovf = of0;
`endif
      end
      2: begin
        m_in_ready = ir2; m_out_valid = ov2; m_sum = s2; m_cout = co2;
`ifdef SEQ_ADDER_OVERFLOW_EN
        m_ovf = of2;
`endif
      end
      default: ;
    endcase
  end

  // Drive one operation with out_ready high; returns latency and captured result
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tbv, input logic tc, input logic ts,
                        output int lat, output logic [15:0] rs, output logic rc, output logic ro);
    int t;
    t = 0;
    a = ta; b = tbv; cin = tc; sub = ts; in_valid = 1'b1; out_ready = 1'b1;
    while (m_in_ready !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (m_out_valid !== 1'b1 && lat < 64) begin @(posedge clk); #1; lat++; end
    rs = m_sum; rc = m_cout;
`ifdef SEQ_ADDER_OVERFLOW_EN
    ro = m_ovf;
`else
    ro = 1'b0;
`endif
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    cur = 1; rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (m_in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%0b exp=0", m_in_ready); end
    total++; if (m_out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", m_out_valid); end
    total++; if (m_sum !== 16'h0000) begin bad++; $display("FAIL reset_sum got=%h exp=0000", m_sum); end
    total++; if (m_cout !== 1'b0) begin bad++; $display("FAIL reset_cout got=%0b exp=0", m_cout); end
    rst = 1'b0;
    #1;
    total++; if (m_in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%0b exp=1", m_in_ready); end
  endtask

  task automatic test_add_sub();
    int lat; logic [15:0] rs; logic rc, ro;
    cur = 1;
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, lat, rs, rc, ro);
    total++; if (lat !== 4) begin bad++; $display("FAIL wrap_latency got=%0d exp=4", lat); end
    total++; if ({rc, rs} !== 17'h1_0000) begin bad++; $display("FAIL wrap_sum got=%b_%h exp=1_0000", rc, rs); end
    run_op(16'h1234, 16'h4321, 1'b1, 1'b0, lat, rs, rc, ro);
    total++; if ({rc, rs} !== 17'h0_5556) begin bad++; $display("FAIL add_cin got=%b_%h exp=0_5556", rc, rs); end
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, lat, rs, rc, ro);
    total++; if ({rc, rs} !== 17'h0_FFFE) begin bad++; $display("FAIL sub_borrow got=%b_%h exp=0_fffe", rc, rs); end
    run_op(16'h0007, 16'h0005, 1'b0, 1'b1, lat, rs, rc, ro);
    total++; if ({rc, rs} !== 17'h1_0002) begin bad++; $display("FAIL sub_noborrow got=%b_%h exp=1_0002", rc, rs); end
    run_op(16'h8000, 16'h8000, 1'b1, 1'b0, lat, rs, rc, ro);
    total++; if ({rc, rs} !== 17'h1_0001) begin bad++; $display("FAIL add_msb got=%b_%h exp=1_0001", rc, rs); end
  endtask

  task automatic test_backpressure();
    int t;
    cur = 1; t = 0;
    a = 16'h00FF; b = 16'h0F01; cin = 1'b0; sub = 1'b0; out_ready = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (m_out_valid !== 1'b1 && t < 64) begin @(posedge clk); #1; t++; end
    total++; if (t !== 4) begin bad++; $display("FAIL bp_latency got=%0d exp=4", t); end
    a = 16'h1111; b = 16'h2222; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      total++; if (m_out_valid !== 1'b1 || m_in_ready !== 1'b0) begin
        bad++; $display("FAIL bp_hold_hs cyc=%0d got ov=%0b ir=%0b exp ov=1 ir=0", i, m_out_valid, m_in_ready); end
      total++; if ({m_cout, m_sum} !== 17'h0_1000) begin
        bad++; $display("FAIL bp_hold_data cyc=%0d got=%b_%h exp=0_1000", i, m_cout, m_sum); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (m_out_valid !== 1'b0 || m_in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_pop got ov=%0b ir=%0b exp ov=0 ir=1", m_out_valid, m_in_ready); end
    total++; if (m_sum !== 16'h1000) begin bad++; $display("FAIL bp_sum_kept got=%h exp=1000", m_sum); end
  endtask

  task automatic test_reset_mid();
    int lat; logic [15:0] rs; logic rc, ro;
    cur = 1;
    a = 16'hAAAA; b = 16'h0001; cin = 1'b0; sub = 1'b0; out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    total++; if (m_in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready got=%0b exp=1", m_in_ready); end
    for (int i = 0; i < 8; i++) begin
      total++; if (m_out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_no_result cyc=%0d got=%0b exp=0", i, m_out_valid); end
      @(posedge clk); #1;
    end
    run_op(16'h0001, 16'h0002, 1'b0, 1'b0, lat, rs, rc, ro);
    total++; if ({rc, rs} !== 17'h0_0003) begin bad++; $display("FAIL rstmid_next_op got=%b_%h exp=0_0003", rc, rs); end
  endtask

  // Back-to-back random operations; in_valid stays high so the accept follows the pop by one cycle
  task automatic test_back_to_back(input int sel, input int nch);
    logic [15:0] ra, rb, rbx; logic rc, rs, eo; logic [16:0] e; int lat;
    cur = sel; out_ready = 1'b1;
    ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
    a = ra; b = rb; cin = rc; sub = rs; in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      rbx = rs ? ~rb : rb;
      e = {1'b0, ra} + {1'b0, rbx} + {16'd0, (rs | rc)};
      eo = (ra[15] == rbx[15]) && (e[15] != ra[15]);
      total++; if (m_in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready chunk_sel=%0d op=%0d got=%0b exp=1", sel, n, m_in_ready); end
      @(posedge clk); #1;
      lat = 0;
      while (m_out_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
      total++; if (lat !== nch) begin bad++; $display("FAIL b2b_latency chunk_sel=%0d op=%0d got=%0d exp=%0d", sel, n, lat, nch); end
      total++; if ({m_cout, m_sum} !== e) begin
        bad++; $display("FAIL b2b_result chunk_sel=%0d op=%0d a=%h b=%h cin=%0b sub=%0b got=%h exp=%h", sel, n, ra, rb, rc, rs, {m_cout, m_sum}, e); end
`ifdef SEQ_ADDER_OVERFLOW_EN
      total++; if (m_ovf !== eo) begin bad++; $display("FAIL b2b_ovf chunk_sel=%0d op=%0d got=%0b exp=%0b", sel, n, m_ovf, eo); end
`else
      if (eo === 1'bx) $display("note: unknown overflow model value");
`endif
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom_range(0, 1)); rs = 1'($urandom_range(0, 1));
      a = ra; b = rb; cin = rc; sub = rs;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

`ifdef SEQ_ADDER_OVERFLOW_EN
  task automatic test_overflow();
    int lat; logic [15:0] rs; logic rc, ro;
    cur = 1;
    run_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, lat, rs, rc, ro);
    total++; if (ro !== 1'b1 || rs !== 16'h8000) begin bad++; $display("FAIL ovf_pos got ovf=%0b sum=%h exp ovf=1 sum=8000", ro, rs); end
    run_op(16'h8000, 16'h0001, 1'b0, 1'b1, lat, rs, rc, ro);
    total++; if (ro !== 1'b1 || rs !== 16'h7FFF) begin bad++; $display("FAIL ovf_sub got ovf=%0b sum=%h exp ovf=1 sum=7fff", ro, rs); end
    run_op(16'h0003, 16'h0004, 1'b0, 1'b0, lat, rs, rc, ro);
    total++; if (ro !== 1'b0 || rs !== 16'h0007) begin bad++; $display("FAIL ovf_none got ovf=%0b sum=%h exp ovf=0 sum=0007", ro, rs); end
  endtask
`endif

  initial begin
    test_reset();
    test_add_sub();
    test_backpressure();
    test_reset_mid();
    test_back_to_back(0, 16);
    test_back_to_back(1, 4);
    test_back_to_back(2, 1);
`ifdef SEQ_ADDER_OVERFLOW_EN
    test_overflow();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
